cook_multi: RTL and testbench

Parametrised successor to the single-pass cooking controller. It tracks an item with `SIDES` faces. Each face must accumulate `COOK_CYCLES` heated cycles, and the operator must flip the item within `FLIP_WINDOW` cycles of being told to. The block reports progress, flip requests, completion and a sticky failure status to the surrounding kitchen-control logic, and sits directly on the `temp`/`flip` sensor inputs.

---
 rtl/cook_pkg.sv | 19 +
 rtl/cook_multi.sv | 98 +++++++++
 tb/tb_cook_multi.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cook_pkg.sv
// Shared status encoding for the cooking controller and its downstream monitors.
package cook_pkg;

    // 2-bit status codes seen on the status output and by display/monitor logic.
    localparam logic [1:0] ST_COOK   = 2'b00;
    localparam logic [1:0] ST_FLIP   = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;
    localparam logic [1:0] ST_RUINED = 2'b11;

    // Controller state; encoding is identical to the published status codes
    // so the status output is the state register itself.
    typedef enum logic [1:0] {
        CS_COOK   = ST_COOK,
        CS_FLIP   = ST_FLIP,
        CS_DONE   = ST_DONE,
        CS_RUINED = ST_RUINED
    } cook_status_t;

endpackage

// File: rtl/cook_multi.sv
// Multi-face cooking controller: counts heated cycles per face, requests a
// flip between faces with a bounded response window, and latches ruin.
module cook_multi
    import cook_pkg::*;
#(
    parameter int SIDES       = 2,
    parameter int COOK_CYCLES = 4,
    parameter int FLIP_WINDOW = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             temp,
    input  logic                             flip,
    output logic [1:0]                       status,
    output logic                             need_flip,
    output logic                             done,
    output logic [$clog2(SIDES+1)-1:0]       sides_done,
    output logic [$clog2(COOK_CYCLES+1)-1:0] heat_cnt
);

    localparam int SW = $clog2(SIDES + 1);
    localparam int HW = $clog2(COOK_CYCLES + 1);
    // Window counter needs at least one bit even when FLIP_WINDOW is 1.
    localparam int WW = (FLIP_WINDOW > 1) ? $clog2(FLIP_WINDOW) : 1;

    localparam logic [HW-1:0] HEAT_LAST = HW'(COOK_CYCLES - 1);
    localparam logic [SW-1:0] SIDE_LAST = SW'(SIDES - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(FLIP_WINDOW - 1);

    cook_status_t  state, state_nx;
    logic [SW-1:0] sides_nx;
    logic [HW-1:0] heat_nx;
    logic [WW-1:0] win, win_nx;

    // State and counter registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CS_COOK;
            sides_done <= '0;
            heat_cnt   <= '0;
            win        <= '0;
        end else begin
            state      <= state_nx;
            sides_done <= sides_nx;
            heat_cnt   <= heat_nx;
            win        <= win_nx;
        end
    end

    // Next-state and counter updates; anything not updated holds, which
    // also freezes all counters once RUINED is reached.
    always_comb begin
        state_nx = state;
        sides_nx = sides_done;
        heat_nx  = heat_cnt;
        win_nx   = win;
        case (state)
            CS_COOK: begin
                if (flip) begin
                    state_nx = CS_RUINED;
                end else if (temp) begin
                    if (heat_cnt == HEAT_LAST) begin
                        sides_nx = sides_done + 1'b1;
                        heat_nx  = '0;
                        if (sides_done == SIDE_LAST) begin
                            state_nx = CS_DONE;
                        end else begin
                            state_nx = CS_FLIP;
                            win_nx   = '0;
                        end
                    end else begin
                        heat_nx = heat_cnt + 1'b1;
                    end
                end
            end
            CS_FLIP: begin
                if (temp) begin
                    state_nx = CS_RUINED;
                end else if (flip) begin
                    state_nx = CS_COOK;
                end else if (win < WIN_LAST) begin
                    win_nx = win + 1'b1;
                end else begin
                    state_nx = CS_RUINED;
                end
            end
            CS_DONE: begin
                if (temp) state_nx = CS_RUINED;
            end
            default: state_nx = CS_RUINED;
        endcase
    end

    assign status    = state;
    assign need_flip = (state == CS_FLIP);
    assign done      = (state == CS_DONE);

endmodule

// File: tb/tb_cook_multi.sv
// Self-checking bench for cook_multi at default parameters: a vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_cook_multi;

    localparam int SIDES       = 2;
    localparam int COOK_CYCLES = 4;
    localparam int FLIP_WINDOW = 2;

    logic       clk = 0;
    logic       reset = 0;
    logic       temp = 0;
    logic       flip = 0;
    logic [1:0] status;
    logic       need_flip;
    logic       done;
    logic [$clog2(SIDES+1)-1:0]       sides_done;
    logic [$clog2(COOK_CYCLES+1)-1:0] heat_cnt;

    int checks = 0;
    int errors = 0;

    cook_multi #(.SIDES(SIDES), .COOK_CYCLES(COOK_CYCLES), .FLIP_WINDOW(FLIP_WINDOW)) dut (
        .clk(clk), .reset(reset), .temp(temp), .flip(flip),
        .status(status), .need_flip(need_flip), .done(done),
        .sides_done(sides_done), .heat_cnt(heat_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 cooking, 1 awaiting flip, 2 finished, 3 ruined.
    int m_phase, m_heat, m_faces, m_wait;

    function automatic void model_reset();
        m_phase = 0; m_heat = 0; m_faces = 0; m_wait = 0;
    endfunction

    function automatic void model_step(input bit t, input bit f);
        if (m_phase == 0) begin
            if (f) m_phase = 3;
            else if (t) begin
                m_heat = m_heat + 1;
                if (m_heat == COOK_CYCLES) begin
                    m_heat  = 0;
                    m_faces = m_faces + 1;
                    m_wait  = 0;
                    m_phase = (m_faces == SIDES) ? 2 : 1;
                end
            end
        end else if (m_phase == 1) begin
            if (t) m_phase = 3;
            else if (f) m_phase = 0;
            else begin
                m_wait = m_wait + 1;
                if (m_wait >= FLIP_WINDOW) m_phase = 3;
            end
        end else if (m_phase == 2) begin
            if (t) m_phase = 3;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int sd, input int hc);
        chk({tag, " status"}, int'(status), st);
        chk({tag, " need_flip"}, int'(need_flip), (st == 1) ? 1 : 0);
        chk({tag, " done"}, int'(done), (st == 2) ? 1 : 0);
        chk({tag, " sides_done"}, int'(sides_done), sd);
        chk({tag, " heat_cnt"}, int'(heat_cnt), hc);
    endtask

    // Drive one cycle of inputs away from the edge, sample just after it.
    task automatic step(input bit t, input bit f);
        @(negedge clk);
        temp = t;
        flip = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        temp  = 0;
        flip  = 0;
        reset = 1;
        #2;
        reset = 0;
        model_reset();
    endtask

    typedef struct {
        bit    rst;
        bit    t;
        bit    f;
        int    st;
        int    sd;
        int    hc;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input bit r, input bit t, input bit f,
                               input int st, input int sd, input int hc, input string n);
        vec_t x;
        x.rst = r; x.t = t; x.f = f; x.st = st; x.sd = sd; x.hc = hc; x.name = n;
        return x;
    endfunction

    initial begin
        // Happy path
        vecs.push_back(v(1, 0, 0, 0, 0, 0, "happy_reset"));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, "happy_h1"));
        vecs.push_back(v(0, 1, 0, 0, 0, 2, "happy_h2"));
        vecs.push_back(v(0, 1, 0, 0, 0, 3, "happy_h3"));
        vecs.push_back(v(0, 1, 0, 1, 1, 0, "happy_face1"));
        vecs.push_back(v(0, 0, 1, 0, 1, 0, "happy_flip"));
        vecs.push_back(v(0, 1, 0, 0, 1, 1, "happy_b1"));
        vecs.push_back(v(0, 1, 0, 0, 1, 2, "happy_b2"));
        vecs.push_back(v(0, 1, 0, 0, 1, 3, "happy_b3"));
        vecs.push_back(v(0, 1, 0, 2, 2, 0, "happy_done"));
        vecs.push_back(v(0, 0, 1, 2, 2, 0, "done_ignores_flip"));
        // Interrupted heat
        vecs.push_back(v(1, 0, 0, 0, 0, 0, "gap_reset"));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, "gap_h1"));
        vecs.push_back(v(0, 1, 0, 0, 0, 2, "gap_h2"));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, "gap_idle1"));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, "gap_idle2"));
        vecs.push_back(v(0, 1, 0, 0, 0, 3, "gap_h3"));
        vecs.push_back(v(0, 1, 0, 1, 1, 0, "gap_face1"));
        // Early flip: counters freeze at their pre-ruin values
        vecs.push_back(v(1, 0, 0, 0, 0, 0, "early_reset"));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, "early_h1"));
        vecs.push_back(v(0, 1, 0, 0, 0, 2, "early_h2"));
        vecs.push_back(v(0, 0, 1, 3, 0, 2, "early_flip"));

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
                #1;
            end else begin
                step(vecs[i].t, vecs[i].f);
            end
            chk_all(vecs[i].name, vecs[i].st, vecs[i].sd, vecs[i].hc);
        end

        // RUINED is sticky for any inputs
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_all("ruined_sticky", 3, 0, 2);
        end

        // Window expiry with no flip
        do_reset();
        repeat (4) step(1, 0);
        step(0, 0);
        chk_all("win_wait1", 1, 1, 0);
        step(0, 0);
        chk_all("win_expire", 3, 1, 0);

        // Flip on the last window cycle
        do_reset();
        repeat (4) step(1, 0);
        step(0, 0);
        step(0, 1);
        chk_all("win_late_flip", 0, 1, 0);

        // Heat during FLIP
        do_reset();
        repeat (4) step(1, 0);
        step(1, 0);
        chk_all("heat_in_flip", 3, 1, 0);

        // Heat after DONE
        do_reset();
        repeat (4) step(1, 0);
        step(0, 1);
        repeat (4) step(1, 0);
        chk_all("reach_done", 2, 2, 0);
        step(0, 0);
        chk_all("done_hold", 2, 2, 0);
        step(1, 0);
        chk_all("overcook", 3, 2, 0);

        // Simultaneous temp and flip in COOK and in FLIP
        do_reset();
        step(1, 1);
        chk_all("both_cook", 3, 0, 0);
        do_reset();
        repeat (4) step(1, 0);
        step(1, 1);
        chk_all("both_flip", 3, 1, 0);

        // Asynchronous reset mid-window, checked before the next edge
        do_reset();
        repeat (4) step(1, 0);
        step(0, 0);
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        chk_all("async_reset", 0, 0, 0);
        #1;
        reset = 0;
        model_reset();
        repeat (3) step(1, 0);
        chk_all("post_reset_h3", 0, 0, 3);
        step(1, 0);
        chk_all("post_reset_face", 1, 1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit t, f;
            if (m_phase >= 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
                #1;
            end else begin
                case (m_phase)
                    0: begin
                        t = ($urandom_range(0, 9) < 7);
                        f = ($urandom_range(0, 19) == 0);
                    end
                    1: begin
                        t = ($urandom_range(0, 9) == 0);
                        f = ($urandom_range(0, 9) < 5);
                    end
                    default: begin
                        t = ($urandom_range(0, 3) == 0);
                        f = ($urandom_range(0, 1) == 0);
                    end
                endcase
                step(t, f);
                model_step(t, f);
            end
            chk_all("rand", m_phase, m_faces, m_heat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
